buscaminas_board_ctrl: RTL and testbench
========================================

// Module: buscaminas_board_ctrl
// PURPOSE
//  Sequencer that builds a Minesweeper board inside the matriz cell storage.
//  On start it performs four phases in order:
//   - clears every cell;
//   - places num_mines mines at pseudo-random positions (LFSR, no duplicates);
//   - writes the adjacent-mine count into every cell;
//   - raises enable_matriz so the game logic may use the board.
//  Sits between the game FSM (start/seed/num_mines) and matriz (read/write port).
// PARAMETERS
//  ROWS    8  board rows; power of two
//  COLS    8  board columns; power of two; ROWS*COLS <= 256
//  CELL_W  5  cell width: bit CELL_W-1 = mine flag, bits 3:0 = neighbour count
// PORTS
//  clk            in   1                 system clock, rising edge
//  reset          in   1                 asynchronous, active-high
//  start          in   1                 1-cycle request; sampled in IDLE/DONE only
//  seed           in   8                 LFSR seed, latched on accepted start
//  num_mines      in   $clog2(ROWS*COLS) requested mine count, latched on start
//  rd_row         out  $clog2(ROWS)      matriz read row address
//  rd_col         out  $clog2(COLS)      matriz read column address
//  rd_data        in   CELL_W            matriz combinational read data (same cycle)
//  wr_en          out  1                 matriz write strobe; written at next edge
//  wr_row         out  $clog2(ROWS)      write row address
//  wr_col         out  $clog2(COLS)      write column address
//  wr_data        out  CELL_W            write data
//  busy           out  1                 high in CLEAR/PLACE/COUNT
//  done           out  1                 1-cycle pulse on entry to DONE
//  enable_matriz  out  1                 board valid; high in DONE until next start
// BEHAVIOUR
//  Reset (async): state=IDLE; all outputs 0; LFSR=8'hA5; internal counters 0.
//  Reset mid-phase aborts to IDLE. Matrix content is then undefined.
//  FSM: IDLE -start-> CLEAR -> PLACE -> COUNT -> DONE -start-> CLEAR.
//   start in CLEAR/PLACE/COUNT is ignored.
//  Accepted start:
//   - latches num_mines, clamped to ROWS*COLS-1;
//   - loads LFSR=seed (seed==0 loads 8'hA5);
//   - drops enable_matriz the next cycle.
//  CLEAR: ROWS*COLS cycles, row-major from (0,0).
//   Each cycle wr_en=1, wr_data=0. Then PLACE.
//  PLACE: one candidate per cycle.
//   - Candidate position: row = lfsr[r+c-1:c], col = lfsr[c-1:0].
//   - rd addr = candidate. If rd_data[CELL_W-1]==0, then wr_en=1,
//     wr_data={1'b1,0...} and placed++. Otherwise no write.
//   - LFSR steps every PLACE cycle: Fibonacci x^8+x^6+x^5+x^4+1, shift left,
//     feedback into bit0.
//   - Exit to COUNT in the cycle after placed==num_mines.
//   - num_mines==0 spends exactly 1 PLACE cycle with no write.
//  COUNT: per cell (row-major), 9 cycles.
//   - Cycles 0-7 read the neighbours in order NW,N,NE,W,E,SW,S,SE and add
//     rd_data[CELL_W-1] to cnt.
//   - Out-of-board neighbours add 0 but still use their cycle; there is no
//     wrap-around.
//   - Cycle 8: rd addr = own cell; wr_en=1, wr_data={rd_data[CELL_W-1],cnt};
//     cnt cleared.
//   - Total 9*ROWS*COLS cycles, then DONE.
//  DONE: done=1 for the entry cycle only. enable_matriz=1, busy=0, wr_en=0.
//  wr_en is 0 in IDLE and DONE. rd/wr addresses hold their last value when unused.
//  cnt is 4 bits; the maximum value is 8, so there is no overflow.
// TESTING
//  1 reset high 3 cycles, then low -> all outputs 0; start during reset has no effect.
//  2 start, num_mines=0, seed=8'h01 -> CLEAR 64 writes; 1 PLACE cycle;
//    COUNT writes 0 to all 64 cells; done pulse exactly 64+1+576 cycles after start.
//  3 num_mines=10, seed=8'h5C -> exactly 10 cells with bit4=1;
//    every cell count equals a software recount of its 8 neighbours.
//  4 num_mines=63 -> 63 mines; the single free cell holds the count of its
//    in-board neighbours (3, 5 or 8).
//  5 start pulsed while busy -> ignored; cycle count identical to scenario 3.
//  6 reset asserted mid-COUNT -> next cycle busy=0, enable_matriz=0, wr_en=0;
//    a new start rebuilds the board correctly.

Source files
------------

// File: rtl/buscaminas_board_ctrl.sv
// -----------------------------------------------------------------------------
// buscaminas_board_ctrl
//
// Builds a Minesweeper board inside the external matriz cell storage. After
// an accepted start it runs four phases in order:
//   CLEAR : write 0 into every cell, row-major from (0,0)
//   PLACE : drop num_mines mines on LFSR-chosen cells, skipping occupied ones
//   COUNT : for each cell, read its 8 neighbours and write back the mine count
//   DONE  : raise enable_matriz so the game logic may use the board
//
// Cell layout: bit CELL_W-1 = mine flag, bits 3:0 = neighbour count.
//
// Ports
//   clk, reset      clock (rising edge) and asynchronous active-high reset
//   start           1-cycle build request, only honoured in IDLE/DONE
//   seed            LFSR seed (0 selects 8'hA5), latched on accepted start
//   num_mines       requested mine count, latched and clamped on start
//   rd_row/rd_col   matriz read address; rd_data returns in the same cycle
//   wr_en/wr_row/   matriz write port; data is stored at the next clock edge
//   wr_col/wr_data
//   busy            high during CLEAR/PLACE/COUNT
//   done            1-cycle pulse on entry to DONE
//   enable_matriz   board valid; high in DONE until the next accepted start
// -----------------------------------------------------------------------------
module buscaminas_board_ctrl #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int CELL_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   seed,
  input  logic [$clog2(ROWS*COLS)-1:0] num_mines,
  output logic [$clog2(ROWS)-1:0]      rd_row,
  output logic [$clog2(COLS)-1:0]      rd_col,
  input  logic [CELL_W-1:0]            rd_data,
  output logic                         wr_en,
  output logic [$clog2(ROWS)-1:0]      wr_row,
  output logic [$clog2(COLS)-1:0]      wr_col,
  output logic [CELL_W-1:0]            wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         enable_matriz
);

  localparam int RB    = $clog2(ROWS);
  localparam int CB    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int IB    = $clog2(CELLS);
  localparam int MINE  = CELL_W - 1;

  localparam logic [IB-1:0]     LAST_CELL    = IB'(CELLS - 1);
  localparam logic [7:0]        LFSR_DEFAULT = 8'hA5;
  localparam logic [CELL_W-1:0] MINE_CELL    = {1'b1, {(CELL_W-1){1'b0}}};
  localparam logic [RB+1:0]     ONE_R        = (RB+2)'(1);
  localparam logic [CB+1:0]     ONE_C        = (CB+2)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t            state;
  logic [IB-1:0]     idx;       // current cell in CLEAR and COUNT
  logic [IB-1:0]     placed;    // mines written so far
  logic [IB-1:0]     mines_q;   // latched, clamped mine target
  logic [3:0]        phase;     // COUNT sub-cycle: 0-7 neighbours, 8 write-back
  logic [3:0]        cnt;       // neighbour mines accumulated for idx
  logic [7:0]        lfsr;

  // Last driven addresses/data, so the ports hold steady when unused.
  logic [RB-1:0]     rd_row_q, wr_row_q;
  logic [CB-1:0]     rd_col_q, wr_col_q;
  logic [CELL_W-1:0] wr_data_q;

  // Only the mine flag of a cell is ever inspected here.
  logic              rd_data_unused;
  assign rd_data_unused = ^rd_data[CELL_W-2:0];

  logic [RB-1:0] cur_row, cand_row;
  logic [CB-1:0] cur_col, cand_col;
  logic [7:0]    lfsr_next;

  assign cur_row   = idx[IB-1:CB];
  assign cur_col   = idx[CB-1:0];
  assign cand_row  = lfsr[RB+CB-1:CB];
  assign cand_col  = lfsr[CB-1:0];
  // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Neighbour address with two guard bits: -1 becomes all ones and ROWS/COLS
  // sets the guard bits, so a cell is on the board iff both guards are 0.
  logic [RB+1:0] dr, nb_row;
  logic [CB+1:0] dc, nb_col;
  logic          nb_in;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    dr = '0;
    dc = '0;
    case (phase)
      4'd0:    begin dr = '1;    dc = '1;    end  // NW
      4'd1:    begin dr = '1;                end  // N
      4'd2:    begin dr = '1;    dc = ONE_C; end  // NE
      4'd3:    begin             dc = '1;    end  // W
      4'd4:    begin             dc = ONE_C; end  // E
      4'd5:    begin dr = ONE_R; dc = '1;    end  // SW
      4'd6:    begin dr = ONE_R;             end  // S
      4'd7:    begin dr = ONE_R; dc = ONE_C; end  // SE
      default: ;
    endcase
  end

  assign nb_row = {2'b00, cur_row} + dr;
  assign nb_col = {2'b00, cur_col} + dc;
  assign nb_in  = (nb_row[RB+1:RB] == 2'b00) && (nb_col[CB+1:CB] == 2'b00);

  // The memory port is combinational on the state registers and rd_data:
  // a PLACE write depends on the cell read in the same cycle, and it must land
  // at the very next edge so a repeated candidate already sees its mine.
  always_comb begin
    rd_row  = rd_row_q;
    rd_col  = rd_col_q;
    wr_en   = 1'b0;
    wr_row  = wr_row_q;
    wr_col  = wr_col_q;
    wr_data = wr_data_q;
    case (state)
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_row  = cur_row;
        wr_col  = cur_col;
        wr_data = '0;
      end
      S_PLACE: begin
        rd_row = cand_row;
        rd_col = cand_col;
        if (placed != mines_q && !rd_data[MINE]) begin
          wr_en   = 1'b1;
          wr_row  = cand_row;
          wr_col  = cand_col;
          wr_data = MINE_CELL;
        end
      end
      S_COUNT: begin
        if (phase == 4'd8) begin
          rd_row        = cur_row;
          rd_col        = cur_col;
          wr_en         = 1'b1;
          wr_row        = cur_row;
          wr_col        = cur_col;
          wr_data       = '0;
          wr_data[MINE] = rd_data[MINE];
          wr_data[3:0]  = cnt;
        end else begin
          // Off-board neighbours still spend their cycle; the wrapped
          // address is read but its data is ignored through nb_in.
          rd_row = nb_row[RB-1:0];
          rd_col = nb_col[CB-1:0];
        end
      end
      default: ;
    endcase
  end

  // NOTE: all state in this block uses non-blocking assignments, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      placed        <= '0;
      mines_q       <= '0;
      phase         <= '0;
      cnt           <= '0;
      lfsr          <= LFSR_DEFAULT;
      busy          <= 1'b0;
      done          <= 1'b0;
      enable_matriz <= 1'b0;
      rd_row_q      <= '0;
      rd_col_q      <= '0;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      wr_data_q     <= '0;
    end else begin
      rd_row_q  <= rd_row;
      rd_col_q  <= rd_col;
      wr_row_q  <= wr_row;
      wr_col_q  <= wr_col;
      wr_data_q <= wr_data;
      done      <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mines_q       <= (num_mines > LAST_CELL) ? LAST_CELL : num_mines;
            lfsr          <= (seed == 8'h00) ? LFSR_DEFAULT : seed;
            idx           <= '0;
            busy          <= 1'b1;
            enable_matriz <= 1'b0;
            state         <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          idx <= idx + IB'(1);
          if (idx == LAST_CELL) begin
            placed <= '0;
            state  <= S_PLACE;
          end
        end

        S_PLACE: begin
          lfsr <= lfsr_next;
          // The exit check uses the registered count, so the target is
          // confirmed one cycle after the last mine (or at once for zero).
          if (placed == mines_q) begin
            idx   <= '0;
            phase <= '0;
            cnt   <= '0;
            state <= S_COUNT;
          end else if (!rd_data[MINE]) begin
            placed <= placed + IB'(1);
          end
        end

        S_COUNT: begin
          if (phase == 4'd8) begin
            phase <= '0;
            cnt   <= '0;
            idx   <= idx + IB'(1);
            if (idx == LAST_CELL) begin
              busy          <= 1'b0;
              done          <= 1'b1;
              enable_matriz <= 1'b1;
              state         <= S_DONE;
            end
          end else begin
            phase <= phase + 4'd1;
            if (nb_in && rd_data[MINE]) cnt <= cnt + 4'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buscaminas_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_buscaminas_board_ctrl
//
// Self-checking bench for buscaminas_board_ctrl. The bench owns a small cell
// memory standing in for matriz, and a reference model that derives the
// expected board (mine set from the seed sequence, neighbour counts by direct
// recount) and the expected build latency.
// -----------------------------------------------------------------------------
module tb_buscaminas_board_ctrl;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int CELL_W = 5;
  localparam int CELLS  = ROWS * COLS;
  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] seed;
  logic [5:0] num_mines;
  logic [2:0] rd_row, rd_col, wr_row, wr_col;
  logic [4:0] rd_data, wr_data;
  logic       wr_en, busy, done, enable_matriz;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  buscaminas_board_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CELL_W(CELL_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .seed         (seed),
    .num_mines    (num_mines),
    .rd_row       (rd_row),
    .rd_col       (rd_col),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .busy         (busy),
    .done         (done),
    .enable_matriz(enable_matriz)
  );

  // matriz stand-in: combinational read, write at the clock edge.
  logic [4:0] mem [CELLS];
  logic       scramble = 1'b0;
  int         wr_count = 0;

  assign rd_data = mem[{rd_row, rd_col}];

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < CELLS; i++) mem[i] <= 5'($urandom);
    end else if (wr_en) begin
      mem[{wr_row, wr_col}] <= wr_data;
    end
    if (wr_en) wr_count <= wr_count + 1;
  end

  // ---------------------------------------------------------------- model
  logic [4:0] exp_mem [CELLS];

  function automatic int lfsr_advance(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  // Fills exp_mem and returns how many PLACE cycles the build should take.
  task automatic build_model(input int sd, input int n, output int place_cycles);
    bit mine [CELLS];
    int l, placed, pos, nb;
    if (n > CELLS - 1) n = CELLS - 1;
    for (int i = 0; i < CELLS; i++) mine[i] = 1'b0;
    l            = (sd == 0) ? 'hA5 : sd;
    placed       = 0;
    place_cycles = 0;
    while (place_cycles < 2000) begin
      place_cycles++;
      if (placed == n) break;
      pos = l % CELLS;
      if (!mine[pos]) begin
        mine[pos] = 1'b1;
        placed++;
      end
      l = lfsr_advance(l);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                c + dc >= 0 && c + dc < COLS && mine[(r + dr) * COLS + c + dc])
              nb++;
        exp_mem[r * COLS + c] = mine[r * COLS + c] ? 5'(16 + nb) : 5'(nb);
      end
    end
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic do_scramble();
    scramble = 1'b1;
    @(posedge clk); #1;
    scramble = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] sd, input logic [5:0] n);
    seed      = sd;
    num_mines = n;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // One full build with all end-to-end checks. With chatter set, start is
  // pulsed randomly (with random seed/num_mines) while the build is busy.
  task automatic run_build(input string name, input logic [7:0] sd, input int n,
                           input bit chatter, output int lat);
    int exp_place, exp_lat, exp_n, w0, cyc, bad_busy, mines_seen;
    build_model(sd, n, exp_place);
    exp_n   = (n > CELLS - 1) ? CELLS - 1 : n;
    exp_lat = CELLS + exp_place + 9 * CELLS;
    do_scramble();
    w0 = wr_count;
    pulse_start(sd, 6'(n));

    tests++;
    if (enable_matriz !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL %s accept: enable=%0b busy=%0b, want enable=0 busy=1",
               name, enable_matriz, busy);
    end

    cyc      = 0;
    bad_busy = 0;
    while (done !== 1'b1 && cyc < BUDGET) begin
      if (chatter) begin
        start     = ($urandom_range(0, 5) == 0);
        seed      = 8'($urandom);
        num_mines = 6'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1 && (busy !== 1'b1 || enable_matriz !== 1'b0)) bad_busy++;
    end
    start = 1'b0;
    lat   = cyc;

    tests++;
    if (done !== 1'b1 || cyc != exp_lat) begin
      fails++;
      $display("FAIL %s latency: done after %0d cycles (done=%0b), want %0d",
               name, cyc, done, exp_lat);
    end
    tests++;
    if (bad_busy != 0) begin
      fails++;
      $display("FAIL %s busy_window: %0d cycles with busy!=1 or enable!=0, want 0",
               name, bad_busy);
    end
    tests++;
    if (busy !== 1'b0 || enable_matriz !== 1'b1 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL %s done_cycle: busy=%0b enable=%0b wr_en=%0b, want 0 1 0",
               name, busy, enable_matriz, wr_en);
    end

    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || enable_matriz !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: done=%0b enable=%0b busy=%0b wr_en=%0b, want 0 1 0 0",
               name, done, enable_matriz, busy, wr_en);
    end
    tests++;
    if (wr_count - w0 != 2 * CELLS + exp_n) begin
      fails++;
      $display("FAIL %s write_count: got %0d writes, want %0d",
               name, wr_count - w0, 2 * CELLS + exp_n);
    end

    mines_seen = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (mem[i][4] === 1'b1) mines_seen++;
      tests++;
      if (mem[i] !== exp_mem[i]) begin
        fails++;
        $display("FAIL %s cell(%0d,%0d): got %b, want %b",
                 name, i / COLS, i % COLS, mem[i], exp_mem[i]);
      end
    end
    tests++;
    if (mines_seen != exp_n) begin
      fails++;
      $display("FAIL %s mine_total: got %0d mines, want %0d", name, mines_seen, exp_n);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b1;
    seed      = 8'h33;
    num_mines = 6'd5;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if ({busy, done, enable_matriz, wr_en} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: busy/done/enable/wr_en=%b, want 0000",
               {busy, done, enable_matriz, wr_en});
    end
    tests++;
    if ({rd_row, rd_col, wr_row, wr_col, wr_data} !== 17'd0) begin
      fails++;
      $display("FAIL reset_ports: rd=%0d,%0d wr=%0d,%0d data=%0d, want all 0",
               rd_row, rd_col, wr_row, wr_col, wr_data);
    end
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b wr_en=%0b, want 0 0", busy, wr_en);
    end
  endtask

  task automatic test_no_mines();
    int lat;
    run_build("no_mines", 8'h01, 0, 1'b0, lat);
    tests++;
    if (lat != 64 + 1 + 576) begin
      fails++;
      $display("FAIL no_mines_latency_const: got %0d, want %0d", lat, 64 + 1 + 576);
    end
  endtask

  task automatic test_full_board();
    int lat, free_cnt, free_idx, r, c, nb;
    logic [7:0] sd;
    sd = 8'($urandom_range(1, 255));
    run_build("full_board", sd, 63, 1'b0, lat);
    free_cnt = 0;
    free_idx = 0;
    for (int i = 0; i < CELLS; i++)
      if (mem[i][4] === 1'b0) begin
        free_cnt++;
        free_idx = i;
      end
    r  = free_idx / COLS;
    c  = free_idx % COLS;
    nb = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
            c + dc >= 0 && c + dc < COLS)
          nb++;
    tests++;
    if (free_cnt != 1 || mem[free_idx] !== 5'(nb)) begin
      fails++;
      $display("FAIL full_board_free_cell: %0d free, cell(%0d,%0d)=%b, want 1 free with %0d",
               free_cnt, r, c, mem[free_idx], nb);
    end
  endtask

  task automatic test_start_while_busy(input int ref_lat);
    int lat;
    run_build("start_while_busy", 8'h5C, 10, 1'b1, lat);
    tests++;
    if (lat != ref_lat) begin
      fails++;
      $display("FAIL start_while_busy_cycles: got %0d, want %0d", lat, ref_lat);
    end
  endtask

  task automatic test_reset_mid_count();
    int exp_place, lat, n;
    logic [7:0] sd;
    sd = 8'($urandom_range(1, 255));
    n  = $urandom_range(1, 40);
    build_model(sd, n, exp_place);
    do_scramble();
    pulse_start(sd, 6'(n));
    repeat (CELLS + exp_place + 200) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_count_busy: busy=%0b before reset, want 1", busy);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || enable_matriz !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL mid_count_async: busy=%0b enable=%0b wr_en=%0b done=%0b, want 0",
               busy, enable_matriz, wr_en, done);
    end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || enable_matriz !== 1'b0 || wr_en !== 1'b0) begin
      fails++;
      $display("FAIL mid_count_next: busy=%0b enable=%0b wr_en=%0b, want 0 0 0",
               busy, enable_matriz, wr_en);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    run_build("rebuild_after_reset", 8'($urandom_range(1, 255)),
              $urandom_range(0, 63), 1'b0, lat);
  endtask

  task automatic test_random_builds();
    int lat;
    for (int k = 0; k < 3; k++)
      run_build("random", 8'($urandom), $urandom_range(0, 63), 1'b0, lat);
  endtask

  initial begin
    int lat_ten;
    start     = 1'b0;
    seed      = 8'h00;
    num_mines = 6'd0;
    test_reset();
    test_no_mines();
    run_build("ten_mines", 8'h5C, 10, 1'b0, lat_ten);
    test_full_board();
    test_start_while_busy(lat_ten);
    run_build("seed_zero", 8'h00, $urandom_range(1, 30), 1'b0, lat_ten);
    test_reset_mid_count();
    test_random_builds();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
